evr_pulse_capture: RTL and testbench

//  Receive-side counterpart of outputDriver: samples a SERDES input word stream in the evrClk domain and

---
 rtl/evr_pulse_capture_if.sv | 39 +++
 rtl/evr_pulse_capture.sv | 108 ++++++++++
 tb/tb_evr_pulse_capture.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/evr_pulse_capture_if.sv
// evr_pulse_capture_if: control, SERDES input and result bundle for evr_pulse_capture
//  master: drives arm/continuous/triggerStrobe/serdesPattern, observes status and results
//  slave : the capture block itself
//  arm, continuous, triggerStrobe  control from the event/CSR side
//  serdesPattern                   deserialized input word, bit 0 earliest
//  busy, armed, resultStrobe       status
//  resultDelay/First/Width/Last    measured pulse in outputDriver encoding
//  timeout, overflow, missCount    result flags and missed-trigger counter
interface evr_pulse_capture_if #(
  parameter int SERDES_WIDTH       = 4,
  parameter int COARSE_DELAY_WIDTH = 22,
  parameter int COARSE_WIDTH_WIDTH = 22,
  parameter int MISS_COUNT_WIDTH   = 8
);
  logic                          arm;
  logic                          continuous;
  logic                          triggerStrobe;
  logic [SERDES_WIDTH-1:0]       serdesPattern;
  logic                          busy;
  logic                          armed;
  logic                          resultStrobe;
  logic [COARSE_DELAY_WIDTH-1:0] resultDelay;
  logic [SERDES_WIDTH-1:0]       resultFirst;
  logic [COARSE_WIDTH_WIDTH-1:0] resultWidth;
  logic [SERDES_WIDTH-1:0]       resultLast;
  logic                          timeout;
  logic                          overflow;
  logic [MISS_COUNT_WIDTH-1:0]   missCount;
  modport master (
    output arm, continuous, triggerStrobe, serdesPattern,
    input  busy, armed, resultStrobe, resultDelay, resultFirst, resultWidth, resultLast,
           timeout, overflow, missCount
  );
  modport slave (
    input  arm, continuous, triggerStrobe, serdesPattern,
    output busy, armed, resultStrobe, resultDelay, resultFirst, resultWidth, resultLast,
           timeout, overflow, missCount
  );
endinterface

// File: rtl/evr_pulse_capture.sv
// evr_pulse_capture: measures the first pulse after each trigger on a SERDES word stream
//  evrClk    sole clock, rising edge
//  evrReset  asynchronous active-high reset
//  bus       evr_pulse_capture_if.slave: control/input words in, status and results out
//  Results use outputDriver's encoding: coarse word delay/width plus first/last edge words.
module evr_pulse_capture #(
  parameter int SERDES_WIDTH       = 4,
  parameter int COARSE_DELAY_WIDTH = 22,
  parameter int COARSE_WIDTH_WIDTH = 22,
  parameter int MISS_COUNT_WIDTH   = 8
) (
  input logic           evrClk,
  input logic           evrReset,
  evr_pulse_capture_if.slave bus
);
  localparam int SW = SERDES_WIDTH;
  localparam int DW = COARSE_DELAY_WIDTH;
  localparam int WW = COARSE_WIDTH_WIDTH;
  localparam int MW = MISS_COUNT_WIDTH;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] SEEK  = 3'd2;
  localparam logic [2:0] HIGH  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] kcnt_q, kcnt_d, dly_q, dly_d, rdly_q, rdly_d;
  logic [WW-1:0] wcnt_q, wcnt_d, rwidth_q, rwidth_d;
  logic [SW-1:0] first_q, first_d, rfirst_q, rfirst_d, rlast_q, rlast_d;
  logic          timeout_q, timeout_d, overflow_q, overflow_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [SW-1:0] w;
  logic [DW-1:0] k;
  logic          busy, seek, rise, fin_seek, fin_high, fin;
  assign w    = bus.serdesPattern;
  assign busy = (state_q == SEEK) | (state_q == HIGH) | (state_q == DONE);
  // The trigger cycle itself is word k=0 and runs the seek logic.
  assign seek = (state_q == SEEK) | ((state_q == ARMED) & bus.triggerStrobe);
  assign k    = (state_q == SEEK) ? kcnt_q : '0;
  assign rise = |w;
  // A rising word with a low MSB already contains the falling edge.
  assign fin_seek = seek & (rise ? ~w[SW-1] : &k);
  assign fin_high = (state_q == HIGH) & (~&w | &wcnt_q);
  assign fin      = fin_seek | fin_high;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = (bus.arm | bus.continuous) ? ARMED : IDLE;
      ARMED, SEEK: state_d = !seek ? state_q : fin ? DONE : rise ? HIGH : SEEK;
      HIGH:        state_d = fin ? DONE : HIGH;
      DONE:        state_d = bus.continuous ? ARMED : IDLE;
      default:     state_d = IDLE;
    endcase
  end
  // The terminating word is always the reported last word: zero on timeout,
  // all-ones on overflow, the partial word otherwise.
  always_comb begin
    kcnt_d     = seek ? k + DW'(1) : kcnt_q;
    wcnt_d     = seek ? WW'(1) : (state_q == HIGH) ? wcnt_q + WW'(1) : wcnt_q;
    dly_d      = (seek & rise) ? k : dly_q;
    first_d    = (seek & rise) ? w : first_q;
    rdly_d     = fin ? (seek ? k : dly_q) : rdly_q;
    rfirst_d   = fin ? (seek ? w : first_q) : rfirst_q;
    rwidth_d   = fin ? (seek ? '0 : wcnt_q) : rwidth_q;
    rlast_d    = fin ? w : rlast_q;
    timeout_d  = fin ? (seek & ~rise) : timeout_q;
    overflow_d = fin ? ((state_q == HIGH) & &w) : overflow_q;
    miss_d     = (busy & bus.triggerStrobe & ~&miss_q) ? miss_q + MW'(1) : miss_q;
  end
  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      state_q    <= IDLE;
      kcnt_q     <= '0;
      wcnt_q     <= '0;
      dly_q      <= '0;
      first_q    <= '0;
      rdly_q     <= '0;
      rfirst_q   <= '0;
      rwidth_q   <= '0;
      rlast_q    <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      kcnt_q     <= kcnt_d;
      wcnt_q     <= wcnt_d;
      dly_q      <= dly_d;
      first_q    <= first_d;
      rdly_q     <= rdly_d;
      rfirst_q   <= rfirst_d;
      rwidth_q   <= rwidth_d;
      rlast_q    <= rlast_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      miss_q     <= miss_d;
    end
  end
  assign bus.busy         = busy;
  assign bus.armed        = state_q == ARMED;
  assign bus.resultStrobe = state_q == DONE;
  assign bus.resultDelay  = rdly_q;
  assign bus.resultFirst  = rfirst_q;
  assign bus.resultWidth  = rwidth_q;
  assign bus.resultLast   = rlast_q;
  assign bus.timeout      = timeout_q;
  assign bus.overflow     = overflow_q;
  assign bus.missCount    = miss_q;
endmodule

// File: tb/tb_evr_pulse_capture.sv
// tb_evr_pulse_capture: directed tests for evr_pulse_capture (full-size and narrow-counter instances)
module tb_evr_pulse_capture;
  logic evrClk = 1'b0, evrReset = 1'b1;
  logic arm = 1'b0, cont = 1'b0, trig = 1'b0, sel = 1'b0;
  logic [3:0] pat = 4'h0;
  int n_chk = 0, n_pass = 0;
  evr_pulse_capture_if i0 ();
  evr_pulse_capture_if #(.SERDES_WIDTH(4), .COARSE_DELAY_WIDTH(4), .COARSE_WIDTH_WIDTH(4),
                         .MISS_COUNT_WIDTH(2)) i1 ();
  assign i0.arm = arm & ~sel;
  assign i1.arm = arm & sel;
  assign i0.continuous = cont & ~sel;
  assign i1.continuous = cont & sel;
  assign i0.triggerStrobe = trig & ~sel;
  assign i1.triggerStrobe = trig & sel;
  assign i0.serdesPattern = pat;
  assign i1.serdesPattern = pat;
  evr_pulse_capture u0 (.evrClk(evrClk), .evrReset(evrReset), .bus(i0));
  evr_pulse_capture #(.SERDES_WIDTH(4), .COARSE_DELAY_WIDTH(4), .COARSE_WIDTH_WIDTH(4),
                      .MISS_COUNT_WIDTH(2)) u1 (.evrClk(evrClk), .evrReset(evrReset), .bus(i1));
  always #5 evrClk = ~evrClk;
  task tick;
    @(posedge evrClk);
    #1;
  endtask
  task do_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task test_reset;
    repeat (2) tick();
    n_chk++; if ({i0.busy, i0.armed, i0.resultStrobe, i0.timeout, i0.overflow} !== 5'b0)
      $display("FAIL reset_status got %b exp 00000", {i0.busy, i0.armed, i0.resultStrobe, i0.timeout, i0.overflow}); else n_pass++;
    n_chk++; if (i0.resultDelay !== 22'd0 || i0.resultWidth !== 22'd0 || i0.resultFirst !== 4'h0 || i0.resultLast !== 4'h0 || i0.missCount !== 8'd0)
      $display("FAIL reset_results got d=%0h w=%0h f=%0h l=%0h m=%0h exp all 0", i0.resultDelay, i0.resultWidth, i0.resultFirst, i0.resultLast, i0.missCount); else n_pass++;
    evrReset = 1'b0;
    repeat (2) tick();
    n_chk++; if (i0.armed !== 1'b0) $display("FAIL reset_stays_idle got armed=%b exp 0", i0.armed); else n_pass++;
  endtask
  task test_basic;
    logic [3:0] v [9];
    int ns;
    v = '{4'h0, 4'h0, 4'h0, 4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 4'h3};
    ns = 0;
    sel = 1'b0;
    do_arm();
    n_chk++; if ({i0.armed, i0.busy} !== 2'b10) $display("FAIL basic_armed got armed,busy=%b exp 10", {i0.armed, i0.busy}); else n_pass++;
    for (int k = 0; k < 9; k++) begin
      pat = v[k];
      trig = (k == 0);
      tick();
      if (k < 8 && i0.resultStrobe) ns++;
      if (k == 4) begin
        n_chk++; if ({i0.busy, i0.armed} !== 2'b10) $display("FAIL basic_busy got busy,armed=%b exp 10", {i0.busy, i0.armed}); else n_pass++;
      end
    end
    trig = 1'b0;
    pat = 4'h0;
    n_chk++; if (ns !== 0) $display("FAIL basic_early_strobe got %0d exp 0", ns); else n_pass++;
    n_chk++; if (i0.resultStrobe !== 1'b1) $display("FAIL basic_strobe got %b exp 1", i0.resultStrobe); else n_pass++;
    n_chk++; if (i0.resultDelay !== 22'd3 || i0.resultFirst !== 4'hC || i0.resultWidth !== 22'd5 || i0.resultLast !== 4'h3 || i0.timeout !== 1'b0 || i0.overflow !== 1'b0)
      $display("FAIL basic_result got d=%0h f=%0h w=%0h l=%0h to=%b ov=%b exp 3 c 5 3 0 0", i0.resultDelay, i0.resultFirst, i0.resultWidth, i0.resultLast, i0.timeout, i0.overflow); else n_pass++;
    tick();
    n_chk++; if ({i0.resultStrobe, i0.armed, i0.busy} !== 3'b000) $display("FAIL basic_after got strobe,armed,busy=%b exp 000", {i0.resultStrobe, i0.armed, i0.busy}); else n_pass++;
    n_chk++; if (i0.resultDelay !== 22'd3 || i0.resultWidth !== 22'd5) $display("FAIL basic_hold got d=%0h w=%0h exp 3 5", i0.resultDelay, i0.resultWidth); else n_pass++;
  endtask
  task test_idle_trigger;
    sel = 1'b0;
    pat = 4'h6;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    n_chk++; if ({i0.resultStrobe, i0.busy, i0.armed} !== 3'b000 || i0.missCount !== 8'd0 || i0.resultDelay !== 22'd3)
      $display("FAIL idle_trig got sbA=%b m=%0h d=%0h exp 000 0 3", {i0.resultStrobe, i0.busy, i0.armed}, i0.missCount, i0.resultDelay); else n_pass++;
  endtask
  task test_k0;
    sel = 1'b0;
    do_arm();
    pat = 4'h6;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    pat = 4'h0;
    n_chk++; if (i0.resultStrobe !== 1'b1 || i0.resultDelay !== 22'd0 || i0.resultFirst !== 4'h6 || i0.resultWidth !== 22'd0 || i0.resultLast !== 4'h6)
      $display("FAIL k0_result got s=%b d=%0h f=%0h w=%0h l=%0h exp 1 0 6 0 6", i0.resultStrobe, i0.resultDelay, i0.resultFirst, i0.resultWidth, i0.resultLast); else n_pass++;
    tick();
    n_chk++; if ({i0.armed, i0.busy, i0.resultStrobe} !== 3'b000) $display("FAIL k0_idle got armed,busy,strobe=%b exp 000", {i0.armed, i0.busy, i0.resultStrobe}); else n_pass++;
  endtask
  task test_loopback;
    int ns;
    ns = 0;
    sel = 1'b0;
    do_arm();
    for (int k = 0; k < 12; k++) begin
      pat = (k < 11) ? 4'hF : 4'h0;
      trig = (k == 0);
      tick();
      if (k < 11 && i0.resultStrobe) ns++;
    end
    trig = 1'b0;
    n_chk++; if (ns !== 0 || i0.resultStrobe !== 1'b1) $display("FAIL loop_strobe got early=%0d s=%b exp 0 1", ns, i0.resultStrobe); else n_pass++;
    n_chk++; if (i0.resultDelay !== 22'd0 || i0.resultFirst !== 4'hF || i0.resultWidth !== 22'd11 || i0.resultLast !== 4'h0)
      $display("FAIL loop_result got d=%0h f=%0h w=%0h l=%0h exp 0 f b 0", i0.resultDelay, i0.resultFirst, i0.resultWidth, i0.resultLast); else n_pass++;
    tick();
  endtask
  task test_timeout;
    int ns;
    ns = 0;
    sel = 1'b1;
    do_arm();
    for (int k = 0; k < 16; k++) begin
      pat = 4'h0;
      trig = (k == 0);
      tick();
      if (k < 15 && i1.resultStrobe) ns++;
    end
    trig = 1'b0;
    n_chk++; if (ns !== 0 || i1.resultStrobe !== 1'b1) $display("FAIL to_strobe got early=%0d s=%b exp 0 1", ns, i1.resultStrobe); else n_pass++;
    n_chk++; if (i1.timeout !== 1'b1 || i1.overflow !== 1'b0 || i1.resultDelay !== 4'hF || i1.resultFirst !== 4'h0 || i1.resultWidth !== 4'h0 || i1.resultLast !== 4'h0)
      $display("FAIL to_result got to=%b ov=%b d=%0h f=%0h w=%0h l=%0h exp 1 0 f 0 0 0", i1.timeout, i1.overflow, i1.resultDelay, i1.resultFirst, i1.resultWidth, i1.resultLast); else n_pass++;
    tick();
  endtask
  task test_overflow;
    int ns;
    ns = 0;
    sel = 1'b1;
    do_arm();
    for (int k = 0; k < 16; k++) begin
      pat = 4'hF;
      trig = (k == 0);
      tick();
      if (k < 15 && i1.resultStrobe) ns++;
    end
    trig = 1'b0;
    pat = 4'h0;
    n_chk++; if (ns !== 0 || i1.resultStrobe !== 1'b1) $display("FAIL ov_strobe got early=%0d s=%b exp 0 1", ns, i1.resultStrobe); else n_pass++;
    n_chk++; if (i1.overflow !== 1'b1 || i1.timeout !== 1'b0 || i1.resultDelay !== 4'h0 || i1.resultFirst !== 4'hF || i1.resultWidth !== 4'hF || i1.resultLast !== 4'hF)
      $display("FAIL ov_result got ov=%b to=%b d=%0h f=%0h w=%0h l=%0h exp 1 0 0 f f f", i1.overflow, i1.timeout, i1.resultDelay, i1.resultFirst, i1.resultWidth, i1.resultLast); else n_pass++;
    tick();
    do_arm();
    pat = 4'h6;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    pat = 4'h0;
    n_chk++; if (i1.resultStrobe !== 1'b1 || i1.overflow !== 1'b0 || i1.resultWidth !== 4'h0 || i1.resultLast !== 4'h6)
      $display("FAIL ov_clear got s=%b ov=%b w=%0h l=%0h exp 1 0 0 6", i1.resultStrobe, i1.overflow, i1.resultWidth, i1.resultLast); else n_pass++;
    tick();
  endtask
  task test_miss_saturate;
    sel = 1'b1;
    do_arm();
    for (int k = 0; k < 8; k++) begin
      pat = (k == 7) ? 4'h6 : 4'h0;
      trig = (k == 0) || (k >= 2 && k <= 5);
      arm = (k == 3);
      tick();
    end
    trig = 1'b0;
    arm = 1'b0;
    pat = 4'h0;
    n_chk++; if (i1.resultStrobe !== 1'b1 || i1.resultDelay !== 4'h7 || i1.resultFirst !== 4'h6 || i1.missCount !== 2'd3)
      $display("FAIL miss_sat got s=%b d=%0h f=%0h m=%0d exp 1 7 6 3", i1.resultStrobe, i1.resultDelay, i1.resultFirst, i1.missCount); else n_pass++;
    tick();
    n_chk++; if ({i1.armed, i1.busy} !== 2'b00) $display("FAIL arm_while_busy got armed,busy=%b exp 00", {i1.armed, i1.busy}); else n_pass++;
  endtask
  task test_continuous;
    int ns, bad;
    ns = 0;
    bad = 0;
    sel = 1'b0;
    cont = 1'b1;
    tick();
    n_chk++; if (i0.armed !== 1'b1) $display("FAIL cont_arm got %b exp 1", i0.armed); else n_pass++;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 28; k++) begin
        pat = (k == 20 || k == 21) ? 4'hF : (k == 22) ? 4'h1 : 4'h0;
        trig = (k == 0) || (r == 0 && (k == 5 || k == 6)) || (r == 1 && k == 8);
        cont = !(r == 2 && k >= 10);
        tick();
        if (i0.resultStrobe) begin
          ns++;
          if (k != 22 || i0.resultDelay !== 22'd20 || i0.resultWidth !== 22'd2 || i0.resultFirst !== 4'hF || i0.resultLast !== 4'h1) bad++;
        end
        if (r == 0 && k == 27) begin
          n_chk++; if (i0.armed !== 1'b1) $display("FAIL cont_rearm got %b exp 1", i0.armed); else n_pass++;
        end
      end
    end
    trig = 1'b0;
    pat = 4'h0;
    cont = 1'b0;
    n_chk++; if (ns !== 3) $display("FAIL cont_strobes got %0d exp 3", ns); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL cont_results got %0d bad exp 0", bad); else n_pass++;
    n_chk++; if (i0.missCount !== 8'd3) $display("FAIL cont_miss got %0d exp 3", i0.missCount); else n_pass++;
    n_chk++; if ({i0.armed, i0.busy} !== 2'b00) $display("FAIL cont_drop got armed,busy=%b exp 00", {i0.armed, i0.busy}); else n_pass++;
  endtask
  task test_reset_mid;
    int ns;
    ns = 0;
    sel = 1'b0;
    do_arm();
    pat = 4'h0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    pat = 4'hC;
    tick();
    pat = 4'hF;
    tick();
    n_chk++; if (i0.busy !== 1'b1) $display("FAIL rst_mid_busy got %b exp 1", i0.busy); else n_pass++;
    evrReset = 1'b1;
    #1;
    n_chk++; if ({i0.busy, i0.armed, i0.resultStrobe, i0.timeout, i0.overflow} !== 5'b0 || i0.resultDelay !== 22'd0 || i0.resultWidth !== 22'd0 || i0.resultFirst !== 4'h0 || i0.resultLast !== 4'h0 || i0.missCount !== 8'd0)
      $display("FAIL rst_mid_outputs got st=%b d=%0h w=%0h f=%0h l=%0h m=%0h exp all 0", {i0.busy, i0.armed, i0.resultStrobe, i0.timeout, i0.overflow}, i0.resultDelay, i0.resultWidth, i0.resultFirst, i0.resultLast, i0.missCount); else n_pass++;
    tick();
    evrReset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (i0.resultStrobe) ns++;
    end
    pat = 4'h0;
    n_chk++; if (ns !== 0 || {i0.armed, i0.busy} !== 2'b00) $display("FAIL rst_mid_idle got strobes=%0d armed,busy=%b exp 0 00", ns, {i0.armed, i0.busy}); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_idle_trigger();
    test_k0();
    test_loopback();
    test_timeout();
    test_overflow();
    test_miss_saturate();
    test_continuous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
